// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file write-back stage.
package regfile_wb_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes (ALU, memory unit) and the register-file write port.
interface regfile_writeback_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_address;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [ADDR_WIDTH-1:0] rf_address;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rf_write;

  modport slave (
    input  alu_valid, alu_address, alu_data,
    input  mem_valid, mem_address, mem_data,
    output alu_ready, mem_ready,
    output rf_address, rf_data, rf_write
  );

  modport master (
    output alu_valid, alu_address, alu_data,
    output mem_valid, mem_address, mem_data,
    input  alu_ready, mem_ready,
    input  rf_address, rf_data, rf_write
  );
endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// Per-source result FIFO; with REGFILE_WB_HAZARD_EN it also exposes per-slot
// destination addresses and valid bits for the hazard compare.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef REGFILE_WB_HAZARD_EN
  ,
  output logic [ADDR_WIDTH-1:0]        tap_addr_o [DEPTH],
  output logic [DEPTH-1:0]             tap_valid_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full is judged before the pop, so a full FIFO never accepts.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

`ifdef REGFILE_WB_HAZARD_EN
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_q;
    assign tap_addr_o[gi]  = mem_q[gi].address;
    assign tap_valid_o[gi] = (CW'(offset) < count_q);
  end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: two buffered producers, round-robin arbitration, one
// registered register-file write per cycle. Optional REGFILE_WB_HAZARD_EN.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_wb_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  regfile_writeback_if.slave              bus,
  input  logic [ADDR_WIDTH-1:0]           select_a_i,
  input  logic [ADDR_WIDTH-1:0]           select_b_i,
  output logic [$clog2(2*DEPTH+1)-1:0]    pending_count_o,
  output logic                            hazard_a_o,
  output logic                            hazard_b_o
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int PCW = $clog2(2*DEPTH+1);

  wb_entry_t              src_in   [2];
  wb_entry_t              src_head [2];
  logic [CW-1:0]          src_count [2];
  logic [1:0]             src_push, src_pop, src_full, src_empty;

  wb_src_t                rr_q, rr_d;
  wb_src_t                grant_src;
  logic                   grant_valid;
  wb_entry_t              grant_entry;

  logic [ADDR_WIDTH-1:0]  rf_address_q, rf_address_d;
  logic [DATA_WIDTH-1:0]  rf_data_q, rf_data_d;
  logic                   rf_write_q, rf_write_d;

  assign src_in[0]   = '{address: bus.alu_address, data: bus.alu_data};
  assign src_in[1]   = '{address: bus.mem_address, data: bus.mem_data};
  assign src_push[0] = bus.alu_valid;
  assign src_push[1] = bus.mem_valid;
  assign bus.alu_ready = !src_full[0] && !rst_i;
  assign bus.mem_ready = !src_full[1] && !rst_i;

`ifdef REGFILE_WB_HAZARD_EN
  logic [1:0] hit_a, hit_b;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
`ifdef REGFILE_WB_HAZARD_EN
    logic [ADDR_WIDTH-1:0] tap_addr [DEPTH];
    logic [DEPTH-1:0]      tap_valid;
    logic [DEPTH-1:0]      match_a, match_b;
`endif
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (src_push[gi]),
      .push_entry_i (src_in[gi]),
      .pop_i        (src_pop[gi]),
      .head_o       (src_head[gi]),
      .full_o       (src_full[gi]),
      .empty_o      (src_empty[gi]),
      .count_o      (src_count[gi])
`ifdef REGFILE_WB_HAZARD_EN
      ,
      .tap_addr_o   (tap_addr),
      .tap_valid_o  (tap_valid)
`endif
    );
`ifdef REGFILE_WB_HAZARD_EN
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_cmp
      assign match_a[gj] = tap_valid[gj] && (tap_addr[gj] == select_a_i);
      assign match_b[gj] = tap_valid[gj] && (tap_addr[gj] == select_b_i);
    end
    assign hit_a[gi] = |match_a;
    assign hit_b[gi] = |match_b;
`endif
  end

  always_comb begin
    rr_d        = rr_q;
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    src_pop     = '0;
    case ({!src_empty[1], !src_empty[0]})
      2'b01: begin grant_valid = 1'b1; grant_src = SRC_ALU; end
      2'b10: begin grant_valid = 1'b1; grant_src = SRC_MEM; end
      2'b11: begin
        grant_valid = 1'b1;
        grant_src   = rr_q;
        rr_d        = (rr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
      end
      default: ;
    endcase
    src_pop[grant_src] = grant_valid;
    grant_entry        = src_head[grant_src];

    // Zero-register entries still load the staging register but never write.
    rf_write_d   = grant_valid && (grant_entry.address != ZERO_REG);
    rf_address_d = grant_valid ? grant_entry.address : rf_address_q;
    rf_data_d    = grant_valid ? grant_entry.data    : rf_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= SRC_ALU;
      rf_write_q   <= 1'b0;
      rf_address_q <= '0;
      rf_data_q    <= '0;
    end else begin
      rr_q         <= rr_d;
      rf_write_q   <= rf_write_d;
      rf_address_q <= rf_address_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign bus.rf_write   = rf_write_q;
  assign bus.rf_address = rf_address_q;
  assign bus.rf_data    = rf_data_q;
  assign pending_count_o = PCW'(src_count[0]) + PCW'(src_count[1]);

`ifdef REGFILE_WB_HAZARD_EN
  assign hazard_a_o = (select_a_i != ZERO_REG) &&
                      ((|hit_a) || (rf_write_q && (rf_address_q == select_a_i)));
  assign hazard_b_o = (select_b_i != ZERO_REG) &&
                      ((|hit_b) || (rf_write_q && (rf_address_q == select_b_i)));
`else
  logic unused_selects;
  assign unused_selects = ^{select_a_i, select_b_i};
  assign hazard_a_o     = 1'b0;
  assign hazard_b_o     = 1'b0;
`endif

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back stage that drives the write port of the 32 x 64 register file. It accepts results from two producers, the ALU and the memory unit, over valid/ready handshakes and buffers each in its own FIFO. It arbitrates between them round-robin and presents at most one registered write per cycle on the register file's address / data_in / write inputs. Writes targeting register 31, the hardwired zero register, are consumed and never issued.

## Interface
- DATA_WIDTH, 64, result width
- ADDR_WIDTH, 5, register address width
- DEPTH, 4, entries per source FIFO (power of two, >= 2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU FIFO can accept
- alu_address  in  ADDR_WIDTH  destination register
- alu_data  in  DATA_WIDTH  result
- mem_valid / mem_ready / mem_address / mem_data  same roles for the memory unit
- rf_address  out  ADDR_WIDTH  to register file address
- rf_data  out  DATA_WIDTH  to register file data_in
- rf_write  out  1  to register file write
- pending_count  out  $clog2(2*DEPTH+1)  total buffered entries (both FIFOs)
- select_a, select_b  in  ADDR_WIDTH  register file read selects (hazard check)
- hazard_a, hazard_b  out  1  read of pending destination

## Operation
- Accept: transfer when valid && ready at the rising edge. ready = !full of that source's FIFO. ready is 0 while reset is asserted.
- A full FIFO does not accept, even in a cycle in which it pops.
- FIFO order is preserved per source. No ordering is guaranteed between sources; producers must use the hazard outputs.
- Arbiter (combinational, each cycle):
  - If exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the source named by rr_ptr, then toggle rr_ptr.
  - rr_ptr is unchanged when fewer than two FIFOs request.
- Granted entry is popped that cycle. At the next edge, the output register loads:
  - rf_address and rf_data from the entry.
  - rf_write = 1 unless address == 31.
- A pop of an address-31 entry gives rf_write = 0 in the following cycle. rf_address and rf_data still load.
- No grant: rf_write loads 0. rf_address and rf_data hold.
- pending_count = ALU count + MEM count. It excludes the output register.

## Timing
- Reset (async) values:
  - FIFOs empty, pointers 0, rr_ptr = ALU.
  - rf_write = 0, rf_address = 0, rf_data = 0.
  - pending_count = 0, hazard_a = hazard_b = 0.
- Accept at edge E: the entry is visible to the arbiter in the cycle after E. If granted then, rf_write = 1 in the cycle after edge E+1. The register file captures at edge E+2.
- Throughput: one register-file write per cycle. Sustained dual-source input of one per cycle each fills the FIFOs; ready then throttles each source to about 1/2.
- Reset asserted mid-operation discards all buffered and staged writes immediately. rf_write drops asynchronously.

## Configuration
- REGFILE_WB_HAZARD_EN defined:
  - hazard_a = (select_a != 31) && select_a matches the address of any valid entry in either FIFO, or matches rf_address while rf_write = 1.
  - hazard_b is the same check for select_b.
  - Both are purely combinational.
- Not defined: hazard_a and hazard_b are tied to 0, and no compare logic is built.

## Structure
- Package regfile_wb_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - ZERO_REG = 31.
  - typedef wb_entry_t {address, data}.
  - enum wb_src_t {SRC_ALU, SRC_MEM} for rr_ptr.
- Sub-module wb_fifo (parameterised by DEPTH):
  - Push, pop, full, empty, count.
  - Per-entry address and valid taps for the hazard compare.
  - Instantiated once per source.

## Test plan
- Reset mid-stream:
  - Stimulus: 3 ALU entries queued, then reset pulsed mid-cycle.
  - Response: rf_write = 0 at once, pending_count = 0. After release, no stale write appears.
- Single write:
  - Stimulus: ALU accepts address 5, data 0x1234 at edge E.
  - Response: rf_write = 1 with rf_address = 5, rf_data = 0x1234 in the cycle after E+1, for exactly one cycle.
- Round-robin:
  - Stimulus: ALU {1,2,3} and MEM {10,11,12} offered every cycle from reset.
  - Response: issue order is 1, 10, 2, 11, 3, 12.
- Backpressure:
  - Stimulus: both sources valid every cycle.
  - Response: each FIFO reaches DEPTH = 4 and its ready drops. pending_count never exceeds 8. No entry is lost or duplicated.
- Zero register:
  - Stimulus: MEM writes address 31 with data 0xFFFF.
  - Response: the entry pops and pending_count decrements, but rf_write stays 0.
- Hazard (macro on):
  - Stimulus: ALU entry for address 7 is pending and select_a = 7.
  - Response: hazard_a = 1 until the cycle after rf_write for 7, then 0.
  - With select_b = 31 and a pending address-31 entry, hazard_b = 0.
